// File: rtl/tiny16_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tiny16_uart_tx
//  Purpose  : FIFO-buffered 8N1 serial transmitter fed by the tiny16 output
//             port (DATA/WR). Define TINY16_UART_PARITY_EN for 8E1 framing.
//  Revision : 1.0 - initial release
// ============================================================================
module tiny16_uart_tx #(
    parameter int CLKS_PER_BIT = 139,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       WR,
    output logic       TX,
    output logic       BUSY,
    output logic       FULL,
    output logic       OVERRUN
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_baud_w = $clog2(CLKS_PER_BIT);

    localparam logic [c_cnt_w-1:0]  c_full_count = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one    = c_ptr_w'(1);
    localparam logic [c_baud_w-1:0] c_baud_max   = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one   = c_baud_w'(1);

`ifdef TINY16_UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_overrun;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_head;

    // Fullness comes from the registered count, so a pop in the same cycle
    // never makes room for a write that arrives while FULL is high.
    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);
    assign w_push  = WR && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (WR && w_full) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [c_baud_w-1:0] r_baud;
    logic [c_baud_w-1:0] w_baud_next;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                w_baud_zero;

    assign w_baud_zero = (r_baud == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_baud_next  = c_baud_max;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_zero) begin
                    w_bit_next   = 3'd0;
                    w_baud_next  = c_baud_max;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud - c_baud_one;
                end
            end
            S_DATA: begin
                if (w_baud_zero) begin
                    w_baud_next = c_baud_max;
                    if (r_bit == 3'd7) begin
`ifdef TINY16_UART_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud - c_baud_one;
                end
            end
`ifdef TINY16_UART_PARITY_EN
            S_PARITY: begin
                if (w_baud_zero) begin
                    w_baud_next  = c_baud_max;
                    w_state_next = S_STOP;
                end else begin
                    w_baud_next = r_baud - c_baud_one;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (w_baud_zero) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_baud_next  = c_baud_max;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud - c_baud_one;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line level is computed from the next state so TX is a pure flop output.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[w_bit_next];
`ifdef TINY16_UART_PARITY_EN
            S_PARITY: w_tx_next = ^w_shift_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign TX      = r_tx;
    assign BUSY    = (r_state != S_IDLE) || !w_empty;
    assign FULL    = w_full;
    assign OVERRUN = r_overrun;

endmodule
`default_nettype wire
